// File: rtl/debug_loader.sv
// debug_loader: byte-serial debug frame decoder.
// Turns CMD / ADDR_HI / ADDR_LO / payload / CHK frames into single-cycle write
// strobes on the instruction memory, data memory or register file debug ports.
// Frames are protected by an XOR checksum and an inter-byte timeout.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; every strobed
// byte is consumed in the cycle it arrives (no ready/backpressure). Each
// *_debug_we is a one-cycle strobe qualifying its waddr/wdata, with no ready.
module debug_loader #(
  parameter int DATA_W         = 8,
  parameter int D_ADDR_W       = 12,
  parameter int INST_W         = 16,
  parameter int I_ADDR_W       = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                debug_enable,
  output logic                imem_debug_we,
  output logic [I_ADDR_W-1:0] imem_debug_waddr,
  output logic [INST_W-1:0]   imem_debug_wdata,
  output logic                dmem_debug_we,
  output logic [D_ADDR_W-1:0] dmem_debug_waddr,
  output logic [DATA_W-1:0]   dmem_debug_wdata,
  output logic                reg_debug_we,
  output logic [3:0]          reg_debug_waddr,
  output logic [DATA_W-1:0]   reg_debug_wdata,
  output logic                busy,
  output logic                err_pulse,
  output logic [2:0]          err_code,
  output logic [7:0]          frames_ok,
  output logic [2:0]          dbg_state_o
);

  localparam logic [7:0] CMD_IMEM = 8'hA1;
  localparam logic [7:0] CMD_DMEM = 8'hA2;
  localparam logic [7:0] CMD_REG  = 8'hA3;

  localparam logic [2:0] ERR_CMD     = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_CHK     = 3'd3;
  localparam logic [2:0] ERR_LOCKED  = 3'd4;

  localparam int              TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Frame capture registers
  logic [7:0]       cmd_q,  cmd_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [7:0]       chk_q,  chk_d;
  logic [TMO_W-1:0] tmo_q,  tmo_d;

  // Output registers
  logic                imem_we_q,    imem_we_d;
  logic [I_ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
  logic [INST_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                dmem_we_q,    dmem_we_d;
  logic [D_ADDR_W-1:0] dmem_waddr_q, dmem_waddr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic                reg_we_q,     reg_we_d;
  logic [3:0]          reg_waddr_q,  reg_waddr_d;
  logic [DATA_W-1:0]   reg_wdata_q,  reg_wdata_d;
  logic                err_pulse_q,  err_pulse_d;
  logic [2:0]          err_code_q,   err_code_d;
  logic [7:0]          frames_q,     frames_d;

  // Decoded events for the current cycle
  logic cmd_known;
  logic bad_cmd;
  logic timeout_hit;
  logic frame_end;
  logic chk_match;

  assign cmd_known   = (rx_data == CMD_IMEM) || (rx_data == CMD_DMEM) || (rx_data == CMD_REG);
  assign bad_cmd     = (state_q == S_IDLE) && rx_valid && !cmd_known;
  // An arriving byte always wins over an expiring timeout.
  assign timeout_hit = (state_q != S_IDLE) && !rx_valid && (tmo_q == TMO_LAST);
  assign frame_end   = (state_q == S_CHECK) && rx_valid;
  assign chk_match   = (rx_data == chk_q);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one step per accepted byte, DATA_HI only for imem frames
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rx_valid && cmd_known) state_d = S_ADDR_HI;
      S_ADDR_HI: if (rx_valid) state_d = S_ADDR_LO;
      S_ADDR_LO: if (rx_valid) state_d = (cmd_q == CMD_IMEM) ? S_DATA_HI : S_DATA_LO;
      S_DATA_HI: if (rx_valid) state_d = S_DATA_LO;
      S_DATA_LO: if (rx_valid) state_d = S_CHECK;
      S_CHECK:   if (rx_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  // FSM outputs: busy flag and raw state for observation
  always_comb begin
    busy        = (state_q != S_IDLE);
    dbg_state_o = state_q;
  end

  // Frame capture: command, address, payload shift, running XOR, timeout count
  always_comb begin
    cmd_d  = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    chk_d  = chk_q;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (cmd_known) begin
            cmd_d = rx_data;
            chk_d = rx_data;
          end
        end
        S_ADDR_HI: begin
          addr_d[15:8] = rx_data;
          chk_d        = chk_q ^ rx_data;
        end
        S_ADDR_LO: begin
          addr_d[7:0] = rx_data;
          chk_d       = chk_q ^ rx_data;
        end
        S_DATA_HI, S_DATA_LO: begin
          data_d = {data_q[7:0], rx_data};
          chk_d  = chk_q ^ rx_data;
        end
        default: ;
      endcase
    end
    if (state_q == S_IDLE || rx_valid || timeout_hit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Commit and error reporting, registered so strobes appear the cycle after the byte
  always_comb begin
    imem_we_d    = 1'b0;
    dmem_we_d    = 1'b0;
    reg_we_d     = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_waddr_d = dmem_waddr_q;
    dmem_wdata_d = dmem_wdata_q;
    reg_waddr_d  = reg_waddr_q;
    reg_wdata_d  = reg_wdata_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    frames_d     = frames_q;
    if (bad_cmd) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_CMD;
    end
    if (timeout_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
    if (frame_end) begin
      if (!chk_match) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_CHK;
      end else if (!debug_enable) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_LOCKED;
      end else begin
        frames_d = frames_q + 8'd1;
        case (cmd_q)
          CMD_IMEM: begin
            imem_we_d    = 1'b1;
            imem_waddr_d = I_ADDR_W'(addr_q);
            imem_wdata_d = INST_W'(data_q);
          end
          CMD_DMEM: begin
            dmem_we_d    = 1'b1;
            dmem_waddr_d = D_ADDR_W'(addr_q);
            dmem_wdata_d = DATA_W'(data_q[7:0]);
          end
          default: begin
            reg_we_d    = 1'b1;
            reg_waddr_d = addr_q[3:0];
            reg_wdata_d = DATA_W'(data_q[7:0]);
          end
        endcase
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      chk_q        <= '0;
      tmo_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_waddr_q <= '0;
      dmem_wdata_q <= '0;
      reg_we_q     <= 1'b0;
      reg_waddr_q  <= '0;
      reg_wdata_q  <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= '0;
      frames_q     <= '0;
    end else begin
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      chk_q        <= chk_d;
      tmo_q        <= tmo_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_waddr_q <= dmem_waddr_d;
      dmem_wdata_q <= dmem_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_waddr_q  <= reg_waddr_d;
      reg_wdata_q  <= reg_wdata_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      frames_q     <= frames_d;
    end
  end

  assign imem_debug_we    = imem_we_q;
  assign imem_debug_waddr = imem_waddr_q;
  assign imem_debug_wdata = imem_wdata_q;
  assign dmem_debug_we    = dmem_we_q;
  assign dmem_debug_waddr = dmem_waddr_q;
  assign dmem_debug_wdata = dmem_wdata_q;
  assign reg_debug_we     = reg_we_q;
  assign reg_debug_waddr  = reg_waddr_q;
  assign reg_debug_wdata  = reg_wdata_q;
  assign err_pulse        = err_pulse_q;
  assign err_code         = err_code_q;
  assign frames_ok        = frames_q;

endmodule

// File: tb/tb_debug_loader.sv
// Testbench for debug_loader: directed frame table, hand-written multi-cycle
// sequences (timeout, timeout boundary, back-to-back frames, mid-frame reset)
// and a randomized byte stream scored against a frame-level reference model.
module tb_debug_loader;

  localparam int TMO  = 16;
  localparam int EV_W = 38;

  // Clock / reset / DUT
  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        debug_enable;
  logic        imem_debug_we;
  logic [11:0] imem_debug_waddr;
  logic [15:0] imem_debug_wdata;
  logic        dmem_debug_we;
  logic [11:0] dmem_debug_waddr;
  logic [7:0]  dmem_debug_wdata;
  logic        reg_debug_we;
  logic [3:0]  reg_debug_waddr;
  logic [7:0]  reg_debug_wdata;
  logic        busy;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [7:0]  frames_ok;
  logic [2:0]  dbg_state_o;

  always #5 clk = ~clk;

  debug_loader #(
    .DATA_W(8), .D_ADDR_W(12), .INST_W(16), .I_ADDR_W(12), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .debug_enable(debug_enable),
    .imem_debug_we(imem_debug_we), .imem_debug_waddr(imem_debug_waddr),
    .imem_debug_wdata(imem_debug_wdata),
    .dmem_debug_we(dmem_debug_we), .dmem_debug_waddr(dmem_debug_waddr),
    .dmem_debug_wdata(dmem_debug_wdata),
    .reg_debug_we(reg_debug_we), .reg_debug_waddr(reg_debug_waddr),
    .reg_debug_wdata(reg_debug_wdata),
    .busy(busy), .err_pulse(err_pulse), .err_code(err_code),
    .frames_ok(frames_ok), .dbg_state_o(dbg_state_o)
  );

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [EV_W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  // Reference model state
  logic [11:0] m_i_addr;
  logic [15:0] m_i_data;
  logic [11:0] m_d_addr;
  logic [7:0]  m_d_data;
  logic [3:0]  m_r_addr;
  logic [7:0]  m_r_data;
  logic [7:0]  m_frames;
  logic [2:0]  m_code;
  bit          m_in_frame;
  logic [7:0]  m_buf[$];
  int          m_need;

  typedef struct packed {
    logic [47:0] bytes;
    logic [3:0]  len;
    logic        en;
    logic [2:0]  kind;   // 0 none, 1 imem, 2 dmem, 3 reg, 4 error
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  code;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EV_W-1:0] ev(input logic [2:0] kind, input logic [2:0] code,
                                         input logic [15:0] addr, input logic [15:0] data);
    return {kind, code, addr, data};
  endfunction

  function automatic vec_t mk(input logic [47:0] bytes, input int len, input logic en,
                              input logic [2:0] kind, input logic [15:0] addr,
                              input logic [15:0] data, input logic [2:0] code);
    vec_t v;
    v.bytes = bytes; v.len = 4'(len); v.en = en; v.kind = kind;
    v.addr = addr; v.data = data; v.code = code;
    return v;
  endfunction

  // Driver tasks (called at #1 after a rising edge, return at the same phase)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic en);
    rx_valid     = 1'b1;
    rx_data      = b;
    debug_enable = en;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Reference model
  task automatic model_reset();
    m_i_addr = '0; m_i_data = '0; m_d_addr = '0; m_d_data = '0;
    m_r_addr = '0; m_r_data = '0; m_frames = '0; m_code = '0;
    m_in_frame = 1'b0; m_buf = {}; m_need = 0;
  endtask

  task automatic note_write(input logic [2:0] kind, input logic [15:0] addr, input logic [15:0] data);
    case (kind)
      3'd1: begin m_i_addr = addr[11:0]; m_i_data = data; end
      3'd2: begin m_d_addr = addr[11:0]; m_d_data = data[7:0]; end
      default: begin m_r_addr = addr[3:0]; m_r_data = data[7:0]; end
    endcase
    m_frames = m_frames + 8'd1;
  endtask

  task automatic model_gap(input int g);
    if (m_in_frame && g >= TMO) begin
      m_in_frame = 1'b0;
      m_code = 3'd2;
      exp_q.push_back(ev(3'd4, 3'd2, 16'h0, 16'h0));
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic en);
    logic [7:0] x;
    logic [2:0] kind;
    logic [15:0] addr, data;
    if (!m_in_frame) begin
      if (b inside {8'hA1, 8'hA2, 8'hA3}) begin
        m_in_frame = 1'b1;
        m_buf = {b};
        m_need = (b == 8'hA1) ? 6 : 5;
      end else begin
        m_code = 3'd1;
        exp_q.push_back(ev(3'd4, 3'd1, 16'h0, 16'h0));
      end
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == m_need) begin
        m_in_frame = 1'b0;
        x = 8'h00;
        for (int i = 0; i < m_need - 1; i++) x = x ^ m_buf[i];
        if (x != b) begin
          m_code = 3'd3;
          exp_q.push_back(ev(3'd4, 3'd3, 16'h0, 16'h0));
        end else if (!en) begin
          m_code = 3'd4;
          exp_q.push_back(ev(3'd4, 3'd4, 16'h0, 16'h0));
        end else begin
          kind = (m_buf[0] == 8'hA1) ? 3'd1 : (m_buf[0] == 8'hA2) ? 3'd2 : 3'd3;
          addr = {m_buf[1], m_buf[2]};
          addr = (kind == 3'd3) ? (addr & 16'h000F) : (addr & 16'h0FFF);
          data = (kind == 3'd1) ? {m_buf[3], m_buf[4]} : {8'h00, m_buf[3]};
          note_write(kind, addr, data);
          exp_q.push_back(ev(kind, 3'd0, addr, data));
        end
      end
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, ".imem_waddr"}, 64'(imem_debug_waddr), 64'(m_i_addr));
    check({tag, ".imem_wdata"}, 64'(imem_debug_wdata), 64'(m_i_data));
    check({tag, ".dmem_waddr"}, 64'(dmem_debug_waddr), 64'(m_d_addr));
    check({tag, ".dmem_wdata"}, 64'(dmem_debug_wdata), 64'(m_d_data));
    check({tag, ".reg_waddr"},  64'(reg_debug_waddr),  64'(m_r_addr));
    check({tag, ".reg_wdata"},  64'(reg_debug_wdata),  64'(m_r_data));
    check({tag, ".frames_ok"},  64'(frames_ok),        64'(m_frames));
    check({tag, ".err_code"},   64'(err_code),         64'(m_code));
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    for (int i = 0; i < int'(v.len); i++) drive_byte(v.bytes[47-8*i -: 8], v.en);
    if (v.kind inside {3'd1, 3'd2, 3'd3}) note_write(v.kind, v.addr, v.data);
    if (v.kind == 3'd4) m_code = v.code;
    check({tag, ".imem_we"},   64'(imem_debug_we), 64'(v.kind == 3'd1));
    check({tag, ".dmem_we"},   64'(dmem_debug_we), 64'(v.kind == 3'd2));
    check({tag, ".reg_we"},    64'(reg_debug_we),  64'(v.kind == 3'd3));
    check({tag, ".err_pulse"}, 64'(err_pulse),     64'(v.kind == 3'd4));
    check_ports(tag);
    idle(1);
    check({tag, ".we_drop"},  64'({imem_debug_we, dmem_debug_we, reg_debug_we}), 64'(0));
    check({tag, ".err_drop"}, 64'(err_pulse), 64'(0));
  endtask

  // Monitor: every write strobe / error pulse must match the next expected event
  task automatic compare_ev(input logic [EV_W-1:0] obs);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL event: got unexpected 0x%0h expected none at %0t", obs, $time);
    end else begin
      check("event", 64'(obs), 64'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if ((int'(imem_debug_we) + int'(dmem_debug_we) + int'(reg_debug_we)) > 1)
        check("we_onehot", 64'({imem_debug_we, dmem_debug_we, reg_debug_we}), 64'(0));
      if (imem_debug_we) compare_ev(ev(3'd1, 3'd0, {4'h0, imem_debug_waddr}, imem_debug_wdata));
      if (dmem_debug_we) compare_ev(ev(3'd2, 3'd0, {4'h0, dmem_debug_waddr}, {8'h00, dmem_debug_wdata}));
      if (reg_debug_we)  compare_ev(ev(3'd3, 3'd0, {12'h000, reg_debug_waddr}, {8'h00, reg_debug_wdata}));
      if (err_pulse)     compare_ev(ev(3'd4, err_code, 16'h0, 16'h0));
    end
  end

  function automatic int pick_gap();
    int p;
    p = $urandom_range(0, 99);
    if (p < 80) return $urandom_range(0, 2);
    if (p < 92) return $urandom_range(3, 8);
    case ($urandom_range(0, 2))
      0:       return TMO - 1;
      1:       return TMO;
      default: return TMO + 3;
    endcase
  endfunction

  initial begin
    logic [7:0] fb[$];
    logic [7:0] cmd, x;
    logic       en;
    int         r, g, flen;
    bit         err_seen;

    // Directed vector table
    vecs[0] = mk(48'hA2_01_23_5A_DA_00, 5, 1'b1, 3'd2, 16'h0123, 16'h005A, 3'd0);
    vecs[1] = mk(48'hA1_00_10_12_34_97, 6, 1'b1, 3'd1, 16'h0010, 16'h1234, 3'd0);
    vecs[2] = mk(48'hA3_00_05_7F_D9_00, 5, 1'b1, 3'd3, 16'h0005, 16'h007F, 3'd0);
    vecs[3] = mk(48'hA3_00_05_7F_00_00, 5, 1'b1, 3'd4, 16'h0000, 16'h0000, 3'd3);
    vecs[4] = mk(48'h55_00_00_00_00_00, 1, 1'b1, 3'd4, 16'h0000, 16'h0000, 3'd1);
    vecs[5] = mk(48'hA2_01_23_5A_DA_00, 5, 1'b0, 3'd4, 16'h0000, 16'h0000, 3'd4);
    vecs[6] = mk(48'hA2_F4_56_99_99_00, 5, 1'b1, 3'd2, 16'h0456, 16'h0099, 3'd0);
    vecs[7] = mk(48'hA3_12_3C_0F_82_00, 5, 1'b1, 3'd3, 16'h000C, 16'h000F, 3'd0);
    vecs[8] = mk(48'hA1_FF_FF_AB_CD_C7, 6, 1'b1, 3'd1, 16'h0FFF, 16'hABCD, 3'd0);

    // Reset
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; debug_enable = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    reset_n = 1'b1;
    model_reset();
    check("rst.busy",  64'(busy), 64'(0));
    check("rst.state", 64'(dbg_state_o), 64'(0));
    check("rst.we",    64'({imem_debug_we, dmem_debug_we, reg_debug_we}), 64'(0));
    check("rst.err",   64'(err_pulse), 64'(0));
    check_ports("rst");

    for (int i = 0; i < 9; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back frames: the byte in the strobe cycle starts a new frame
    for (int i = 0; i < 5; i++) drive_byte(vecs[0].bytes[47-8*i -: 8], 1'b1);
    note_write(3'd2, 16'h0123, 16'h005A);
    check("b2b.dmem_we", 64'(dmem_debug_we), 64'(1));
    for (int i = 0; i < 5; i++) drive_byte(vecs[2].bytes[47-8*i -: 8], 1'b1);
    note_write(3'd3, 16'h0005, 16'h007F);
    check("b2b.reg_we", 64'(reg_debug_we), 64'(1));
    check("b2b.err", 64'(err_pulse), 64'(0));
    check_ports("b2b");
    idle(1);

    // Timeout after TMO idle cycles mid-frame
    drive_byte(8'hA2, 1'b1);
    drive_byte(8'h01, 1'b1);
    idle(TMO - 1);
    check("tmo.busy_before", 64'(busy), 64'(1));
    check("tmo.err_before",  64'(err_pulse), 64'(0));
    idle(1);
    m_code = 3'd2;
    check("tmo.err_pulse", 64'(err_pulse), 64'(1));
    check("tmo.busy",      64'(busy), 64'(0));
    check("tmo.we",        64'({imem_debug_we, dmem_debug_we, reg_debug_we}), 64'(0));
    check_ports("tmo");
    apply_vec("tmo.after", vecs[0]);

    // Byte arriving in the would-be timeout cycle wins
    drive_byte(8'hA2, 1'b1);
    drive_byte(8'h01, 1'b1);
    idle(TMO - 1);
    check("tmoedge.busy", 64'(busy), 64'(1));
    drive_byte(8'h23, 1'b1);
    drive_byte(8'h5A, 1'b1);
    drive_byte(8'hDA, 1'b1);
    note_write(3'd2, 16'h0123, 16'h005A);
    check("tmoedge.dmem_we", 64'(dmem_debug_we), 64'(1));
    check("tmoedge.err",     64'(err_pulse), 64'(0));
    check_ports("tmoedge");
    idle(1);

    // Reset in the middle of an imem frame
    drive_byte(8'hA1, 1'b1);
    drive_byte(8'h00, 1'b1);
    drive_byte(8'h10, 1'b1);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    model_reset();
    check("midrst.busy", 64'(busy), 64'(0));
    check_ports("midrst");
    err_seen = 1'b0;
    for (int i = 0; i < TMO + 2; i++) begin
      idle(1);
      err_seen = err_seen | err_pulse | imem_debug_we;
    end
    check("midrst.quiet", 64'(err_seen), 64'(0));
    apply_vec("midrst.frame", vecs[0]);

    // Randomized stream against the reference model
    mon_en = 1'b1;
    for (int f = 0; f < 450; f++) begin
      fb = {};
      r  = $urandom_range(0, 99);
      en = ($urandom_range(0, 99) < 85);
      if (r < 8) begin
        x = 8'($urandom);
        if (x inside {8'hA1, 8'hA2, 8'hA3}) x = 8'h00;
        fb.push_back(x);
      end else begin
        case ($urandom_range(0, 2))
          0:       cmd = 8'hA1;
          1:       cmd = 8'hA2;
          default: cmd = 8'hA3;
        endcase
        fb.push_back(cmd);
        fb.push_back(8'($urandom));
        fb.push_back(8'($urandom));
        fb.push_back(8'($urandom));
        if (cmd == 8'hA1) fb.push_back(8'($urandom));
        x = 8'h00;
        foreach (fb[i]) x = x ^ fb[i];
        if ($urandom_range(0, 99) < 10) x = x ^ 8'($urandom_range(1, 255));
        fb.push_back(x);
        if ($urandom_range(0, 99) < 5) begin
          flen = $urandom_range(1, fb.size() - 1);
          while (fb.size() > flen) void'(fb.pop_back());
        end
      end
      foreach (fb[i]) begin
        g = pick_gap();
        model_gap(g);
        idle(g);
        model_byte(fb[i], en);
        drive_byte(fb[i], en);
      end
    end
    model_gap(TMO + 2);
    idle(TMO + 2);
    idle(3);
    mon_en = 1'b0;
    check("rand.exp_q_empty", 64'(exp_q.size()), 64'(0));
    check_ports("rand.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
